uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver and the downstream partner of the transmitter stage. It takes the serial line driven by the TX block, oversamples it with the shared 16x `baud_rate` tick and recovers 8N1 frames. Bits arrive MSB first, matching the transmitter's shift order. Each recovered byte is presented on a parallel bus with a one-cycle completion strobe, and a bad stop bit is flagged.

## Interface
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: `baud_rate` ticks spent in the stop bit before sampling it.
- `OVS`, 16: ticks per bit. Fixed; the half-bit point is `OVS/2 - 1` = 7.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `baud_rate` input 1: oversampling enable, one `clk` cycle wide, 16 per bit period; synchronous to `clk`.
- `rx` input 1: serial line, idle high; asynchronous to `clk`.
- `d_out` output DBIT: last correctly framed byte; holds between frames.
- `rx_done` output 1: one-cycle pulse when `d_out` updates.
- `frame_err` output 1: one-cycle pulse when the stop bit samples low.

## Operation
Synchronizer:
- `rx` passes through two flops, both reset to 1, giving `rx_s`. All decisions use `rx_s`.

Registers:
- state, tick counter `s_cnt` (4 bit), bit counter `n` (3 bit), shift register `b` (DBIT).
- Counters advance only in cycles with `baud_rate`=1.

States:
- **IDLE**
  - `rx_s`=0 -> START, `s_cnt`=0. No tick is needed to leave IDLE.
- **START**, on tick:
  - `s_cnt`<7: increment `s_cnt`.
  - `s_cnt`=7 and `rx_s`=0: -> DATA, `s_cnt`=0, `n`=0.
  - `s_cnt`=7 and `rx_s`=1: false start, -> IDLE, no output activity.
- **DATA**, on tick:
  - `s_cnt`<15: increment `s_cnt`.
  - `s_cnt`=15: `b`={`b`[DBIT-2:0], `rx_s`}, `s_cnt`=0.
  - If `n`=DBIT-1 -> STOP, else increment `n`.
  - The first data bit received ends in `b`[7] (MSB first).
- **STOP**, on tick:
  - `s_cnt`<SB_TICK-1: increment `s_cnt`.
  - `s_cnt`=SB_TICK-1 and `rx_s`=1: `d_out`<=`b`, `rx_done`<=1, -> IDLE.
  - `s_cnt`=SB_TICK-1 and `rx_s`=0: `frame_err`<=1, `d_out` unchanged, -> IDLE.

General rules:
- `rx_done` and `frame_err` are registered, mutually exclusive, and cleared the following cycle.
- In IDLE the receiver re-arms immediately. A start bit following the stop sample is accepted with no gap.
- `rx` changes between ticks have no effect except via the synchronizer.

## Timing
- Reset values: `d_out`=0, `rx_done`=0, `frame_err`=0, state IDLE, counters 0, `b`=0, sync flops 1.
- Reset mid-frame: the partial frame is discarded, no strobe is issued, and the receiver returns to IDLE on the next edge.
- Input latency: 2 `clk` cycles from `rx` to `rx_s`.
- Sample points, in ticks after START entry:
  - start bit checked at tick 8 (mid-bit);
  - data bit k sampled 16(k+1)+8 ticks after START entry;
  - stop bit sampled SB_TICK ticks after the last data sample.
- `rx_done` / `frame_err` go high the cycle after the clock edge that consumes the final stop tick.
- `d_out` is valid in that same cycle and stays stable until the next good frame.
- Throughput: one frame per 10 bit periods, back-to-back with no idle time.
- `baud_rate` held high continuously behaves as a tick every cycle; no special handling.

## Test plan
- Frame 0xA5 MSB first at 16 ticks/bit, with `baud_rate` every 4 clk -> exactly one `rx_done` pulse, `d_out`=0xA5, `frame_err`=0.
- `rx` low glitch lasting 4 ticks, then high -> back in IDLE, no `rx_done` or `frame_err`, `d_out` unchanged. A following 0x3C frame is received correctly.
- Frame 0x81 with stop bit driven 0 -> one `frame_err` pulse, no `rx_done`, `d_out` keeps the previous value 0x3C.
- Back-to-back frames 0x00, 0xFF, 0x5A with no idle between -> three `rx_done` pulses, `d_out` sequence 0x00, 0xFF, 0x5A.
- `rst` asserted after the 3rd data bit of 0xC3 -> next cycle all outputs 0 and no strobe. A subsequent 0x96 frame is received correctly.
- Loopback with the TX block sharing `baud_rate`: for all 256 values of `d_in`, pulse `tx_start` -> `d_out`==`d_in` on each `rx_done`, and `frame_err` never asserts.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, 16x oversampled, MSB first.
// A two-flop synchronizer feeds a four-state FSM that checks the start bit
// at mid-bit, then samples each data bit and the stop bit one bit period apart.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            baud_rate,
    input  logic            rx,
    output logic [DBIT-1:0] d_out,
    output logic            rx_done,
    output logic            frame_err
);
    localparam int OVS = 16;
    localparam int NW  = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [3:0]    HALF_LAST = 4'(OVS / 2 - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(OVS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic            rx_m, rx_s;
    logic [1:0]      state;
    logic [3:0]      s_cnt;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;

    // Bring the asynchronous line into the clk domain; idle level is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Frame FSM: counters only move on baud ticks, strobes last one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s_cnt     <= '0;
            n         <= '0;
            b         <= '0;
            d_out     <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Re-arm without waiting for a tick so back-to-back frames fit.
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_rate) begin
                        if (s_cnt != HALF_LAST) begin
                            s_cnt <= s_cnt + 4'd1;
                        end else if (!rx_s) begin
                            state <= DATA;
                            s_cnt <= '0;
                            n     <= '0;
                        end else begin
                            // Line went back high before mid-bit: glitch, not a start.
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (baud_rate) begin
                        if (s_cnt != BIT_LAST) begin
                            s_cnt <= s_cnt + 4'd1;
                        end else begin
                            b     <= {b[DBIT-2:0], rx_s};
                            s_cnt <= '0;
                            if (n == N_LAST) state <= STOP;
                            else             n     <= n + 1'b1;
                        end
                    end
                end
                default: begin
                    if (baud_rate) begin
                        if (s_cnt != STOP_LAST) begin
                            s_cnt <= s_cnt + 4'd1;
                        end else begin
                            // Bad stop bit keeps the previous good byte on d_out.
                            if (rx_s) begin
                                d_out   <= b;
                                rx_done <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= IDLE;
                            s_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven directed frames, hand-written glitch/reset
// sequences, a 256-value loopback through a behavioural serializer, and
// random frames with random stop-bit validity checked against a byte-level model.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_rate = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] d_out;
    logic       rx_done, frame_err;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int div = 4;
    int bcnt = 0;
    logic prev_strobe = 1'b0;
    logic [7:0] model_last = 8'h00;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .rst(rst), .baud_rate(baud_rate), .rx(rx),
        .d_out(d_out), .rx_done(rx_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Tick generator: one tick every div clocks, updated away from the active edge.
    always @(negedge clk) begin
        bcnt = (bcnt + 1 >= div) ? 0 : bcnt + 1;
        baud_rate = (bcnt == 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Strobe monitor: count pulses, require exclusivity and one-cycle width.
    always @(negedge clk) begin
        if (rx_done)   done_cnt++;
        if (frame_err) err_cnt++;
        if (rx_done || frame_err) begin
            checks++;
            if ((rx_done && frame_err) || prev_strobe) begin
                failures++;
                $display("FAIL strobe_shape actual=done%0b/err%0b/prev%0b required=single one-cycle pulse",
                         rx_done, frame_err, prev_strobe);
            end
        end
        prev_strobe = rx_done | frame_err;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            do @(posedge clk); while (!baud_rate);
        end
        #1;
    endtask

    // Serializer at 16 ticks/bit. A bad stop bit is low for 12 ticks (covering
    // the mid-bit sample) and then returns high so no real start follows.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int gap);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 7; i >= 0; i--) begin
            rx = d[i];
            wait_ticks(16);
        end
        if (stop_ok) begin
            rx = 1'b1;
            wait_ticks(16);
        end else begin
            rx = 1'b0;
            wait_ticks(12);
            rx = 1'b1;
            wait_ticks(4);
        end
        wait_ticks(gap);
    endtask

    // Send one frame and compare strobe counts and d_out with the model.
    task automatic frame_check(input string nm, input logic [7:0] d, input logic stop_ok, input int gap);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(d, stop_ok, gap);
        if (stop_ok) model_last = d;
        @(negedge clk);
        chk({nm, "_done"}, done_cnt - d0, stop_ok ? 1 : 0);
        chk({nm, "_ferr"}, err_cnt - e0, stop_ok ? 0 : 1);
        chk({nm, "_dout"}, d_out, model_last);
    endtask

    typedef struct {
        logic       glitch;
        logic [7:0] data;
        logic       stop_ok;
        int         gap;
        int         exp_done;
        int         exp_err;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t tbl[6];
    int   vals[256];

    initial begin
        tbl[0] = '{1'b0, 8'hA5, 1'b1, 4, 1, 0, 8'hA5};
        tbl[1] = '{1'b1, 8'h3C, 1'b1, 4, 1, 0, 8'h3C};
        tbl[2] = '{1'b0, 8'h81, 1'b0, 4, 0, 1, 8'h3C};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 0, 1, 0, 8'h00};
        tbl[4] = '{1'b0, 8'hFF, 1'b1, 0, 1, 0, 8'hFF};
        tbl[5] = '{1'b0, 8'h5A, 1'b1, 4, 1, 0, 8'h5A};

        // Reset state.
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", d_out, 8'h00);
        chk("rst_done", rx_done, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        rst = 1'b0;
        wait_ticks(20);

        // Directed table, baud_rate every 4 clk.
        for (int i = 0; i < 6; i++) begin
            int d0, e0;
            if (tbl[i].glitch) begin
                d0 = done_cnt;
                e0 = err_cnt;
                rx = 1'b0;
                wait_ticks(4);
                rx = 1'b1;
                wait_ticks(20);
                @(negedge clk);
                chk("glitch_done", done_cnt - d0, 0);
                chk("glitch_ferr", err_cnt - e0, 0);
                chk("glitch_dout", d_out, 8'hA5);
            end
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(tbl[i].data, tbl[i].stop_ok, tbl[i].gap);
            @(negedge clk);
            chk($sformatf("tbl%0d_done", i), done_cnt - d0, tbl[i].exp_done);
            chk($sformatf("tbl%0d_ferr", i), err_cnt - e0, tbl[i].exp_err);
            chk($sformatf("tbl%0d_dout", i), d_out, tbl[i].exp_dout);
        end

        // Reset after the third data bit of 0xC3 (bits 1,1,0 sent so far).
        begin
            int d0, e0;
            d0 = done_cnt;
            e0 = err_cnt;
            rx = 1'b0;
            wait_ticks(16);
            rx = 1'b1; wait_ticks(16);
            rx = 1'b1; wait_ticks(16);
            rx = 1'b0; wait_ticks(16);
            @(negedge clk);
            rst = 1'b1;
            rx  = 1'b1;
            @(negedge clk);
            chk("midrst_dout", d_out, 8'h00);
            chk("midrst_done", rx_done, 1'b0);
            chk("midrst_ferr", frame_err, 1'b0);
            rst = 1'b0;
            model_last = 8'h00;
            wait_ticks(200);
            @(negedge clk);
            chk("midrst_quiet_done", done_cnt - d0, 0);
            chk("midrst_quiet_ferr", err_cnt - e0, 0);
            frame_check("after_rst", 8'h96, 1'b1, 4);
        end

        // Loopback: every byte in shuffled order, baud_rate held high, back-to-back.
        div = 1;
        for (int i = 0; i < 256; i++) vals[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = vals[i]; vals[i] = vals[j]; vals[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            frame_check("loop", 8'(vals[i]), 1'b1, $urandom_range(2, 0));
        end

        // Random frames with random stop validity, baud_rate every 3 clk.
        div = 3;
        wait_ticks(4);
        for (int i = 0; i < 24; i++) begin
            frame_check("rand", 8'($urandom), ($urandom_range(3, 0) != 0), $urandom_range(6, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
